// File: rtl/asteroid_pkg.sv
// rtl/asteroid_pkg.sv - shared screen/border geometry, 12-bit colour type, flash states
package asteroid_pkg;

    localparam int SCREEN_WIDTH  = 1440;
    localparam int SCREEN_HEIGHT = 890;
    localparam int BORDER_LEFT   = 50;
    localparam int BORDER_RIGHT  = 50;
    localparam int BORDER_BOTTOM = 100;

    typedef logic [11:0] rgb12_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } flash_state_t;

endpackage

// File: rtl/flash_ctrl.sv
// rtl/flash_ctrl.sv - hit-flash FSM with frame counter and blink phase output
module flash_ctrl
    import asteroid_pkg::*;
#(
    parameter int FLASH_FRAMES = 60,
    parameter int FLASH_PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic collision,
    input  logic frame_tick,
    output logic flash_active,
    output logic flash_phase
);

    localparam int         PHASE_BIT  = $clog2(FLASH_PERIOD);
    localparam logic [7:0] LAST_FRAME = 8'(FLASH_FRAMES - 1);

    flash_state_t r_state;
    flash_state_t w_state_nxt;
    logic [7:0]   r_frame_cnt;
    logic [7:0]   w_frame_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    // A collision always wins, including against the terminal frame tick.
    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        if (collision) begin
            w_state_nxt     = FLASH;
            w_frame_cnt_nxt = '0;
        end else if ((r_state == FLASH) && frame_tick) begin
            if (r_frame_cnt == LAST_FRAME) begin
                w_state_nxt     = IDLE;
                w_frame_cnt_nxt = '0;
            end else begin
                w_frame_cnt_nxt = r_frame_cnt + 8'd1;
            end
        end
    end

    assign flash_active = (r_state == FLASH);
    assign flash_phase  = flash_active && r_frame_cnt[PHASE_BIT];

endmodule

// File: rtl/pixel_compositor.sv
// rtl/pixel_compositor.sv - two-stage layer compositor to VGA pins; hit flash under COMPOSITOR_FLASH_EN
module pixel_compositor
    import asteroid_pkg::rgb12_t;
#(
    parameter int     SCREEN_WIDTH  = asteroid_pkg::SCREEN_WIDTH,
    parameter int     SCREEN_HEIGHT = asteroid_pkg::SCREEN_HEIGHT,
    parameter int     BORDER_LEFT   = asteroid_pkg::BORDER_LEFT,
    parameter int     BORDER_RIGHT  = asteroid_pkg::BORDER_RIGHT,
    parameter int     BORDER_BOTTOM = asteroid_pkg::BORDER_BOTTOM,
    parameter rgb12_t BG_RGB        = 12'h000,
    parameter int     FLASH_FRAMES  = 60,
    parameter int     FLASH_PERIOD  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] curr_x,
    input  logic [9:0]  curr_y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [3:0]  border_r,
    input  logic [3:0]  border_g,
    input  logic [3:0]  border_b,
    input  logic [11:0] ship_rgb,
    input  logic        ship_on,
    input  logic [11:0] ast_rgb,
    input  logic        ast_on,
    input  logic        collision,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        flash_active
);

    localparam logic [10:0] X_LO = 11'(BORDER_LEFT);
    localparam logic [10:0] X_HI = 11'(SCREEN_WIDTH - BORDER_RIGHT);
    localparam logic [9:0]  Y_HI = 10'(SCREEN_HEIGHT - BORDER_BOTTOM);

    logic   w_border_zone;
    logic   r1_border_zone;
    logic   r1_video_on;
    logic   r1_hs;
    logic   r1_vs;
    rgb12_t r1_ship_rgb;
    logic   r1_ship_on;
    rgb12_t r1_ast_rgb;
    logic   r1_ast_on;
    rgb12_t w_playfield;
    rgb12_t w_pix;
    rgb12_t r2_pix;
    logic   r2_hs;
    logic   r2_vs;
    logic   w_invert;

    assign w_border_zone = (curr_x < X_LO) || (curr_x >= X_HI) || (curr_y >= Y_HI);

    // Stage 1 lines the layers up with the painter's one-cycle BRAM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_border_zone <= 1'b0;
            r1_video_on    <= 1'b0;
            r1_hs          <= 1'b1;
            r1_vs          <= 1'b1;
            r1_ship_rgb    <= '0;
            r1_ship_on     <= 1'b0;
            r1_ast_rgb     <= '0;
            r1_ast_on      <= 1'b0;
        end else begin
            r1_border_zone <= w_border_zone;
            r1_video_on    <= video_on;
            r1_hs          <= hsync_in;
            r1_vs          <= vsync_in;
            r1_ship_rgb    <= ship_rgb;
            r1_ship_on     <= ship_on;
            r1_ast_rgb     <= ast_rgb;
            r1_ast_on      <= ast_on;
        end
    end

`ifdef COMPOSITOR_FLASH_EN
    logic r1_frame_tick;
    logic w_flash_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_frame_tick <= 1'b0;
        end else begin
            r1_frame_tick <= (curr_x == 11'd0) && (curr_y == 10'd0);
        end
    end

    flash_ctrl #(
        .FLASH_FRAMES (FLASH_FRAMES),
        .FLASH_PERIOD (FLASH_PERIOD)
    ) u_flash_ctrl (
        .clk          (clk),
        .rst          (rst),
        .collision    (collision),
        .frame_tick   (r1_frame_tick),
        .flash_active (flash_active),
        .flash_phase  (w_flash_phase)
    );

    assign w_invert = w_flash_phase;
`else
    logic w_unused_collision;

    assign w_unused_collision = collision;
    assign flash_active       = 1'b0;
    assign w_invert           = 1'b0;
`endif

    // Border pixels bypass the flash inversion; only the playfield blinks.
    always_comb begin
        w_playfield = BG_RGB;
        if (r1_ship_on) begin
            w_playfield = r1_ship_rgb;
        end else if (r1_ast_on) begin
            w_playfield = r1_ast_rgb;
        end
        w_pix = w_playfield ^ {12{w_invert}};
        if (!r1_video_on) begin
            w_pix = 12'h000;
        end else if (r1_border_zone) begin
            w_pix = {border_r, border_g, border_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r2_pix <= '0;
            r2_hs  <= 1'b1;
            r2_vs  <= 1'b1;
        end else begin
            r2_pix <= w_pix;
            r2_hs  <= r1_hs;
            r2_vs  <= r1_vs;
        end
    end

    assign vga_r  = r2_pix[11:8];
    assign vga_g  = r2_pix[7:4];
    assign vga_b  = r2_pix[3:0];
    assign vga_hs = r2_hs;
    assign vga_vs = r2_vs;

endmodule
